// File: rtl/dist_ram_pkg.sv
// rtl/dist_ram_pkg.sv - shared types and helpers for the distributed RAM controller
// Contents:
//   ctrl_state_t : burst sequencer states (IDLE, READ, DRAIN)
//   wrap_inc     : pointer increment modulo an arbitrary (non power-of-two) depth
package dist_ram_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } ctrl_state_t;

  function automatic int unsigned wrap_inc(input int unsigned ptr, input int unsigned depth);
    if (ptr + 32'd1 >= depth) begin
      return 32'd0;
    end
    return ptr + 32'd1;
  endfunction

endpackage

// File: rtl/dist_ram_ctrl_if.sv
// rtl/dist_ram_ctrl_if.sv - write, burst-control and burst-output bundle of the controller
// Signals:
//   wr_valid/wr_ready/wr_addr/wr_data : single-word write port
//   rd_start/rd_base/rd_len           : burst request (sampled only while idle)
//   rd_busy/rd_done                   : burst status
//   out_valid/out_ready/out_data      : burst data stream to the consumer
// Modports: master = host/loader + consumer side, slave = controller side.
interface dist_ram_ctrl_if #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDRESS_WIDTH = 5
);

  logic                     wr_valid;
  logic                     wr_ready;
  logic [ADDRESS_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0]    wr_data;

  logic                     rd_start;
  logic [ADDRESS_WIDTH-1:0] rd_base;
  logic [ADDRESS_WIDTH:0]   rd_len;
  logic                     rd_busy;
  logic                     rd_done;

  logic                     out_valid;
  logic                     out_ready;
  logic [DATA_WIDTH-1:0]    out_data;

  modport master (
    output wr_valid, wr_addr, wr_data, rd_start, rd_base, rd_len, out_ready,
    input  wr_ready, rd_busy, rd_done, out_valid, out_data
  );

  modport slave (
    input  wr_valid, wr_addr, wr_data, rd_start, rd_base, rd_len, out_ready,
    output wr_ready, rd_busy, rd_done, out_valid, out_data
  );

endinterface

// File: rtl/dist_ram.sv
// rtl/dist_ram.sv - distributed RAM, registered write, combinational read
// Ports:
//   clk      : write clock
//   write_en : write strobe
//   in_addr  : write address (out-of-range addresses are ignored)
//   data_in  : write data
//   out_addr : read address
//   data_out : read data (zero for out-of-range addresses)
// Contents are never cleared.
module dist_ram #(
  parameter int DATA_WIDTH    = 8,
  parameter int DATA_DEPTH    = 32,
  parameter int ADDRESS_WIDTH = 5
) (
  input  logic                     clk,
  input  logic                     write_en,
  input  logic [ADDRESS_WIDTH-1:0] in_addr,
  input  logic [DATA_WIDTH-1:0]    data_in,
  input  logic [ADDRESS_WIDTH-1:0] out_addr,
  output logic [DATA_WIDTH-1:0]    data_out
);

  localparam logic [ADDRESS_WIDTH:0] DEPTH_W = (ADDRESS_WIDTH + 1)'(DATA_DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [DATA_DEPTH];

  always_ff @(posedge clk) begin
    if (write_en && ({1'b0, in_addr} < DEPTH_W)) begin
      mem_q[in_addr] <= data_in;
    end
  end

  always_comb begin
    data_out = '0;
    if ({1'b0, out_addr} < DEPTH_W) begin
      data_out = mem_q[out_addr];
    end
  end

endmodule

// File: rtl/dist_ram_ctrl.sv
// rtl/dist_ram_ctrl.sv - sequences single-word writes and wrapping burst reads of one dist_ram
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : dist_ram_ctrl_if.slave (write port, burst control/status, burst output stream)
// Writes that would land on a word the running burst has not yet loaded are stalled,
// so a burst returns its range as it stood when the burst was accepted.
module dist_ram_ctrl
  import dist_ram_pkg::*;
#(
  parameter int DATA_WIDTH    = 8,
  parameter int DATA_DEPTH    = 32,
  parameter int ADDRESS_WIDTH = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  dist_ram_ctrl_if.slave    bus
);

  localparam logic [ADDRESS_WIDTH:0] DEPTH_W = (ADDRESS_WIDTH + 1)'(DATA_DEPTH);

  ctrl_state_t              state_q,     state_d;
  logic [ADDRESS_WIDTH-1:0] rd_ptr_q,    rd_ptr_d;
  logic [ADDRESS_WIDTH:0]   remaining_q, remaining_d;
  logic                     out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0]    out_data_q,  out_data_d;
  logic                     rd_done_q,   rd_done_d;
  logic                     rd_busy_q,   rd_busy_d;

  logic [DATA_WIDTH-1:0]    ram_rdata;
  logic                     ram_we;
  logic [ADDRESS_WIDTH:0]   len_eff;
  logic [ADDRESS_WIDTH:0]   wr_addr_w;
  logic [ADDRESS_WIDTH:0]   rd_ptr_w;
  logic [ADDRESS_WIDTH:0]   win_off;
  logic                     wr_in_range;
  logic                     in_window;
  logic                     load;

  assign len_eff     = (bus.rd_len > DEPTH_W) ? DEPTH_W : bus.rd_len;
  assign wr_addr_w   = {1'b0, bus.wr_addr};
  assign rd_ptr_w    = {1'b0, rd_ptr_q};
  assign wr_in_range = (wr_addr_w < DEPTH_W);

  // Distance of the write address ahead of the read pointer, modulo depth.
  // Words at distance < remaining have not been loaded yet.
  assign win_off   = (wr_addr_w >= rd_ptr_w) ? (wr_addr_w - rd_ptr_w)
                                             : (wr_addr_w + DEPTH_W - rd_ptr_w);
  assign in_window = (state_q == READ) && wr_in_range && (win_off < remaining_q);

  assign bus.wr_ready = !in_window;
  assign ram_we       = bus.wr_valid && !in_window && wr_in_range;

  // Output register is free when empty or being consumed this cycle.
  assign load = (state_q == READ) && (!out_valid_q || bus.out_ready);

  dist_ram #(
    .DATA_WIDTH   (DATA_WIDTH),
    .DATA_DEPTH   (DATA_DEPTH),
    .ADDRESS_WIDTH(ADDRESS_WIDTH)
  ) u_ram (
    .clk     (clk),
    .write_en(ram_we),
    .in_addr (bus.wr_addr),
    .data_in (bus.wr_data),
    .out_addr(rd_ptr_q),
    .data_out(ram_rdata)
  );

  always_comb begin
    state_d     = state_q;
    rd_ptr_d    = rd_ptr_q;
    remaining_d = remaining_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    rd_done_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.rd_start) begin
          if (len_eff == '0) begin
            rd_done_d = 1'b1;
          end else begin
            rd_ptr_d    = bus.rd_base;
            remaining_d = len_eff;
            state_d     = READ;
          end
        end
      end
      READ: begin
        if (load) begin
          out_data_d  = ram_rdata;
          out_valid_d = 1'b1;
          rd_ptr_d    = ADDRESS_WIDTH'(wrap_inc(32'(rd_ptr_q), 32'(DATA_DEPTH)));
          remaining_d = remaining_q - 1'b1;
          if (remaining_q == (ADDRESS_WIDTH + 1)'(1)) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (out_valid_q && bus.out_ready) begin
          out_valid_d = 1'b0;
          rd_done_d   = 1'b1;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    rd_busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rd_ptr_q    <= '0;
      remaining_q <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      rd_done_q   <= 1'b0;
      rd_busy_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_ptr_q    <= rd_ptr_d;
      remaining_q <= remaining_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      rd_done_q   <= rd_done_d;
      rd_busy_q   <= rd_busy_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.rd_done   = rd_done_q;
  assign bus.rd_busy   = rd_busy_q;

endmodule

// File: tb/tb_dist_ram_ctrl.sv
// tb/tb_dist_ram_ctrl.sv - scoreboard bench for dist_ram_ctrl
module tb_dist_ram_ctrl;

  localparam int DW = 8;
  localparam int DD = 32;
  localparam int AW = 5;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  always #5 clk = ~clk;

  dist_ram_ctrl_if #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) bus ();

  dist_ram_ctrl #(
    .DATA_WIDTH   (DW),
    .DATA_DEPTH   (DD),
    .ADDRESS_WIDTH(AW)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int checks   = 0;
  int failures = 0;

  logic [DW-1:0] ref_mem [DD];
  logic [DW-1:0] exp_q [$];
  bit            tb_busy  = 1'b0;
  bit            done_due = 1'b0;
  int            bbase    = 0;
  int            blen     = 0;
  int            hs       = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor / scoreboard: samples 2 time units after each falling edge.
  initial begin
    bit            busy_now;
    bit            exp_ready;
    int            loaded;
    int            len;
    int            base;
    logic [DW-1:0] exp_word;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_rd_busy",   32'(bus.rd_busy),   32'd0);
        check("rst_rd_done",   32'(bus.rd_done),   32'd0);
        check("rst_out_data",  32'(bus.out_data),  32'd0);
        exp_q.delete();
        tb_busy  = 1'b0;
        done_due = 1'b0;
        hs       = 0;
        continue;
      end
      busy_now = tb_busy;
      check("rd_done", 32'(bus.rd_done), 32'(done_due));
      done_due = 1'b0;
      check("rd_busy", 32'(bus.rd_busy), 32'(busy_now));

      if (bus.wr_valid) begin
        exp_ready = 1'b1;
        if (busy_now && (32'(bus.wr_addr) < DD)) begin
          loaded = hs + (bus.out_valid ? 1 : 0);
          for (int i = loaded; i < blen; i++) begin
            if (((bbase + i) % DD) == int'(bus.wr_addr)) exp_ready = 1'b0;
          end
        end
        check("wr_ready", 32'(bus.wr_ready), 32'(exp_ready));
        if (bus.wr_ready && (32'(bus.wr_addr) < DD)) ref_mem[bus.wr_addr] = bus.wr_data;
      end

      if (bus.out_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL out_unexpected: got out_valid=1 data=%0h expected no word", bus.out_data);
        end else if (bus.out_ready) begin
          exp_word = exp_q.pop_front();
          check("out_data", 32'(bus.out_data), 32'(exp_word));
          hs++;
          if (hs == blen) begin
            tb_busy  = 1'b0;
            done_due = 1'b1;
          end
        end else begin
          check("out_data_held", 32'(bus.out_data), 32'(exp_q[0]));
        end
      end

      if (bus.rd_start && !busy_now) begin
        len  = (int'(bus.rd_len) > DD) ? DD : int'(bus.rd_len);
        base = int'(bus.rd_base);
        if (len == 0) begin
          done_due = 1'b1;
        end else begin
          for (int i = 0; i < len; i++) exp_q.push_back(ref_mem[(base + i) % DD]);
          bbase   = base;
          blen    = len;
          hs      = 0;
          tb_busy = 1'b1;
        end
      end
    end
  end

  task automatic do_write(input int addr, input int data, output int waits);
    bus.wr_valid = 1'b1;
    bus.wr_addr  = AW'(addr);
    bus.wr_data  = DW'(data);
    waits        = 0;
    #1;
    while (!bus.wr_ready && waits < 300) begin
      @(negedge clk);
      #1;
      waits++;
    end
    if (!bus.wr_ready) begin
      checks++;
      failures++;
      $display("FAIL write_timeout: addr %0d never accepted, expected acceptance", addr);
    end
    @(negedge clk);
    bus.wr_valid = 1'b0;
  endtask

  task automatic start_burst(input int base, input int len);
    bus.rd_start = 1'b1;
    bus.rd_base  = AW'(base);
    bus.rd_len   = (AW + 1)'(len);
    @(negedge clk);
    bus.rd_start = 1'b0;
  endtask

  task automatic wait_idle();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 300 && (tb_busy || exp_q.size() != 0); i++) @(negedge clk);
    if (tb_busy || exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL burst_timeout: %0d words still pending, expected 0", exp_q.size());
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int w;
    int w6;
    bus.wr_valid  = 1'b0;
    bus.wr_addr   = '0;
    bus.wr_data   = '0;
    bus.rd_start  = 1'b0;
    bus.rd_base   = '0;
    bus.rd_len    = '0;
    bus.out_ready = 1'b0;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int a = 0; a < DD; a++) do_write(a, int'($urandom_range(0, 255)), w);

    // basic write/read
    do_write(1, 8'hAB, w);
    do_write(2, 8'hFE, w);
    bus.out_ready = 1'b1;
    start_burst(1, 2);
    wait_idle();

    // backpressure
    bus.out_ready = 1'b0;
    start_burst(1, 2);
    repeat (4) @(negedge clk);
    wait_idle();

    // reset mid-burst, then confirm RAM retained
    bus.out_ready = 1'b1;
    start_burst(1, 8);
    for (int i = 0; i < 50 && hs < 2; i++) @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    start_burst(1, 1);
    wait_idle();

    // wrap-around
    do_write(30, 8'h10, w);
    do_write(31, 8'h11, w);
    do_write(0,  8'h12, w);
    do_write(1,  8'h13, w);
    start_burst(30, 4);
    wait_idle();

    // hazard
    bus.out_ready = 1'b0;
    start_burst(4, 8);
    do_write(20, 8'h55, w);
    check("hazard_far_waits", 32'(w), 32'd0);
    fork
      do_write(6, 8'h66, w6);
      begin
        repeat (4) @(negedge clk);
        bus.out_ready = 1'b1;
      end
    join
    check("hazard_near_blocked", 32'(w6 > 0), 32'd1);
    wait_idle();

    // edge lengths
    start_burst(5, 0);
    repeat (3) @(negedge clk);
    start_burst(7, 40);
    wait_idle();

    // randomized traffic
    for (int c = 0; c < 800; c++) begin
      bus.out_ready = ($urandom_range(0, 3) != 0);
      bus.wr_valid  = 1'b0;
      bus.rd_start  = 1'b0;
      if (!tb_busy && $urandom_range(0, 5) == 0) begin
        bus.rd_start = 1'b1;
        bus.rd_base  = AW'($urandom_range(0, DD - 1));
        bus.rd_len   = (AW + 1)'($urandom_range(0, 40));
      end else begin
        if (tb_busy && $urandom_range(0, 9) == 0) begin
          bus.rd_start = 1'b1;
          bus.rd_base  = AW'($urandom_range(0, DD - 1));
          bus.rd_len   = (AW + 1)'($urandom_range(1, 40));
        end
        if ($urandom_range(0, 1) == 1) begin
          bus.wr_valid = 1'b1;
          bus.wr_addr  = AW'($urandom_range(0, DD - 1));
          bus.wr_data  = DW'($urandom_range(0, 255));
        end
      end
      @(negedge clk);
    end
    bus.wr_valid = 1'b0;
    bus.rd_start = 1'b0;
    wait_idle();
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
